// File: rtl/qos_occupancy_tracker.sv
// qos_occupancy_tracker
//   Tracks live fill levels and peaks of NUM_Q queues from enqueue/dequeue
//   strobes. On each frame_start it takes a snapshot that stays stable for
//   the whole frame, so the VGA renderer can read it by queue index.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous active-high reset
//   enq, deq     per-queue enqueue / dequeue strobes (one packet per cycle)
//   frame_start  one-cycle pulse at the start of a display frame
//   clear_flags  clears the sticky overflow / underflow flags
//   rd_sel       snapshot read index
//   rd_level     snapshot level of queue rd_sel, 1-cycle latency
//   rd_peak      snapshot peak of queue rd_sel, 1-cycle latency
//   snap_valid   a snapshot has been taken since reset
//   snap_done    pulse in the cycle after a snapshot
//   ovf_flags    sticky: enqueue while full
//   udf_flags    sticky: dequeue while empty
module qos_occupancy_tracker #(
    parameter int unsigned NUM_Q = 4,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NUM_Q-1:0] enq,
    input  logic [NUM_Q-1:0] deq,
    input  logic             frame_start,
    input  logic             clear_flags,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [CNT_W-1:0] rd_level,
    output logic [CNT_W-1:0] rd_peak,
    output logic             snap_valid,
    output logic             snap_done,
    output logic [NUM_Q-1:0] ovf_flags,
    output logic [NUM_Q-1:0] udf_flags
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] level_q      [NUM_Q];
    logic [CNT_W-1:0] level_d      [NUM_Q];
    logic [CNT_W-1:0] peak_q       [NUM_Q];
    logic [CNT_W-1:0] snap_level_q [NUM_Q];
    logic [CNT_W-1:0] snap_peak_q  [NUM_Q];
    logic [NUM_Q-1:0] ovf_set;
    logic [NUM_Q-1:0] udf_set;
    logic [CNT_W-1:0] rd_level_d;
    logic [CNT_W-1:0] rd_peak_d;

    function automatic logic [CNT_W-1:0] max_cnt(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Next live level and error events; simultaneous enq+deq is cut-through.
    always_comb begin
        ovf_set = '0;
        udf_set = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            level_d[q] = level_q[q];
            case ({enq[q], deq[q]})
                2'b10: begin
                    if (level_q[q] == FULL) ovf_set[q] = 1'b1;
                    else                    level_d[q] = level_q[q] + ONE;
                end
                2'b01: begin
                    if (level_q[q] == '0) udf_set[q] = 1'b1;
                    else                  level_d[q] = level_q[q] - ONE;
                end
                default: ;
            endcase
        end
    end

    // Snapshot read mux; indices with no queue behind them read as zero.
    always_comb begin
        rd_level_d = '0;
        rd_peak_d  = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            if (rd_sel == SEL_W'(q)) begin
                rd_level_d = snap_level_q[q];
                rd_peak_d  = snap_peak_q[q];
            end
        end
    end

    // Live levels, peak windows and frame snapshots.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int q = 0; q < NUM_Q; q++) begin
                level_q[q]      <= '0;
                peak_q[q]       <= '0;
                snap_level_q[q] <= '0;
                snap_peak_q[q]  <= '0;
            end
        end else begin
            for (int q = 0; q < NUM_Q; q++) begin
                level_q[q] <= level_d[q];
                if (frame_start) begin
                    snap_level_q[q] <= level_q[q];
                    snap_peak_q[q]  <= max_cnt(peak_q[q], level_q[q]);
                    peak_q[q]       <= level_d[q];
                end else begin
                    peak_q[q]       <= max_cnt(peak_q[q], level_d[q]);
                end
            end
        end
    end

    // Registered readout and status; a new set event beats clear_flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_level   <= '0;
            rd_peak    <= '0;
            snap_valid <= 1'b0;
            snap_done  <= 1'b0;
            ovf_flags  <= '0;
            udf_flags  <= '0;
        end else begin
            rd_level   <= rd_level_d;
            rd_peak    <= rd_peak_d;
            snap_valid <= snap_valid | frame_start;
            snap_done  <= frame_start;
            ovf_flags  <= (clear_flags ? '0 : ovf_flags) | ovf_set;
            udf_flags  <= (clear_flags ? '0 : udf_flags) | udf_set;
        end
    end

endmodule

// File: tb/tb_qos_occupancy_tracker.sv
// Self-checking bench for qos_occupancy_tracker: directed scenarios followed
// by random traffic, all compared cycle by cycle with a behavioural model.
module tb_qos_occupancy_tracker;

    localparam int NQ    = 4;
    localparam int DEPTH = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] enq, deq;
    logic       frame_start, clear_flags;
    logic [1:0] rd_sel;
    logic [3:0] rd_level, rd_peak;
    logic       snap_valid, snap_done;
    logic [3:0] ovf_flags, udf_flags;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int m_lvl[NQ], m_pk[NQ], m_slvl[NQ], m_spk[NQ];
    int m_rdl, m_rdp, m_valid, m_done, m_ovf, m_udf;

    qos_occupancy_tracker #(.NUM_Q(4), .DEPTH(8), .CNT_W(4), .SEL_W(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .enq         (enq),
        .deq         (deq),
        .frame_start (frame_start),
        .clear_flags (clear_flags),
        .rd_sel      (rd_sel),
        .rd_level    (rd_level),
        .rd_peak     (rd_peak),
        .snap_valid  (snap_valid),
        .snap_done   (snap_done),
        .ovf_flags   (ovf_flags),
        .udf_flags   (udf_flags)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int q = 0; q < NQ; q++) begin
            m_lvl[q] = 0; m_pk[q] = 0; m_slvl[q] = 0; m_spk[q] = 0;
        end
        m_rdl = 0; m_rdp = 0; m_valid = 0; m_done = 0; m_ovf = 0; m_udf = 0;
    endtask

    // One clock edge of the specified behaviour, using the applied inputs.
    task automatic model_step();
        int nl[NQ];
        int ovs, uds;
        ovs = 0; uds = 0;
        m_rdl = m_slvl[rd_sel];
        m_rdp = m_spk[rd_sel];
        for (int q = 0; q < NQ; q++) begin
            nl[q] = m_lvl[q];
            if (enq[q] && !deq[q]) begin
                if (m_lvl[q] == DEPTH) ovs |= (1 << q);
                else nl[q] = m_lvl[q] + 1;
            end else if (deq[q] && !enq[q]) begin
                if (m_lvl[q] == 0) uds |= (1 << q);
                else nl[q] = m_lvl[q] - 1;
            end
        end
        for (int q = 0; q < NQ; q++) begin
            if (frame_start) begin
                m_slvl[q] = m_lvl[q];
                m_spk[q]  = (m_pk[q] > m_lvl[q]) ? m_pk[q] : m_lvl[q];
                m_pk[q]   = nl[q];
            end else if (nl[q] > m_pk[q]) begin
                m_pk[q] = nl[q];
            end
            m_lvl[q] = nl[q];
        end
        m_ovf   = clear_flags ? ovs : (m_ovf | ovs);
        m_udf   = clear_flags ? uds : (m_udf | uds);
        if (frame_start) m_valid = 1;
        m_done  = frame_start;
    endtask

    task automatic check_all();
        check("rd_level",   int'(rd_level),   m_rdl);
        check("rd_peak",    int'(rd_peak),    m_rdp);
        check("snap_valid", int'(snap_valid), m_valid);
        check("snap_done",  int'(snap_done),  m_done);
        check("ovf_flags",  int'(ovf_flags),  m_ovf);
        check("udf_flags",  int'(udf_flags),  m_udf);
    endtask

    // Apply inputs at the falling edge, clock once, compare just after the edge.
    task automatic cycle(input logic [3:0] e, input logic [3:0] d, input logic fs,
                         input logic cf, input logic [1:0] sel);
        enq = e; deq = d; frame_start = fs; clear_flags = cf; rd_sel = sel;
        @(posedge clock);
        model_step();
        #1;
        check_all();
        @(negedge clock);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rd_level"},   int'(rd_level),   0);
        check({tag, "_rd_peak"},    int'(rd_peak),    0);
        check({tag, "_snap_valid"}, int'(snap_valid), 0);
        check({tag, "_snap_done"},  int'(snap_done),  0);
        check({tag, "_ovf"},        int'(ovf_flags),  0);
        check({tag, "_udf"},        int'(udf_flags),  0);
    endtask

    initial begin
        reset = 1'b1; enq = '0; deq = '0; frame_start = 1'b0;
        clear_flags = 1'b0; rd_sel = '0;
        model_reset();
        #1;
        check_zero_outputs("reset");
        @(negedge clock);
        reset = 1'b0;

        // empty snapshot, read all queues
        cycle(4'h0, 4'h0, 1'b1, 1'b0, 2'd0);
        check("first_snap_done", int'(snap_done), 1);
        for (int s = 0; s < NQ; s++) cycle(4'h0, 4'h0, 1'b0, 1'b0, 2'(s));
        cycle(4'h0, 4'h0, 1'b0, 1'b0, 2'd0);

        // q1: 3 enq, 1 deq -> level 2, peak 3; then a quiet frame -> peak 2
        repeat (3) cycle(4'b0010, 4'h0, 1'b0, 1'b0, 2'd1);
        cycle(4'h0, 4'b0010, 1'b0, 1'b0, 2'd1);
        cycle(4'h0, 4'h0, 1'b1, 1'b0, 2'd1);
        cycle(4'h0, 4'h0, 1'b0, 1'b0, 2'd1);
        check("q1_level", int'(rd_level), 2);
        check("q1_peak",  int'(rd_peak),  3);
        cycle(4'h0, 4'h0, 1'b1, 1'b0, 2'd1);
        cycle(4'h0, 4'h0, 1'b0, 1'b0, 2'd1);
        check("q1_peak_restart", int'(rd_peak), 2);

        // q2 saturation, q0 underflow
        repeat (10) cycle(4'b0100, 4'h0, 1'b0, 1'b0, 2'd2);
        check("q2_ovf", int'(ovf_flags), 4);
        cycle(4'h0, 4'b0001, 1'b0, 1'b0, 2'd0);
        check("q0_udf", int'(udf_flags), 1);
        cycle(4'h0, 4'h0, 1'b1, 1'b0, 2'd2);
        cycle(4'h0, 4'h0, 1'b0, 1'b0, 2'd2);
        check("q2_sat_level", int'(rd_level), 8);
        cycle(4'h0, 4'h0, 1'b0, 1'b0, 2'd0);
        check("q0_empty_level", int'(rd_level), 0);

        // q3 cut-through at empty and full, then clear vs new overflow
        cycle(4'h0, 4'h0, 1'b0, 1'b1, 2'd3);
        cycle(4'b1000, 4'b1000, 1'b0, 1'b0, 2'd3);
        repeat (8) cycle(4'b1000, 4'h0, 1'b0, 1'b0, 2'd3);
        cycle(4'b1000, 4'b1000, 1'b0, 1'b0, 2'd3);
        check("cut_through_no_flags", int'(ovf_flags | udf_flags), 0);
        cycle(4'b1000, 4'h0, 1'b0, 1'b1, 2'd3);
        check("set_beats_clear", int'(ovf_flags), 8);
        cycle(4'h0, 4'h0, 1'b1, 1'b0, 2'd3);
        cycle(4'h0, 4'h0, 1'b0, 1'b0, 2'd3);
        check("q3_full_level", int'(rd_level), 8);

        // q0: snapshot at 5, grow to 6 mid-frame, rd_sel held at 0
        repeat (5) cycle(4'b0001, 4'h0, 1'b0, 1'b0, 2'd0);
        cycle(4'h0, 4'h0, 1'b1, 1'b0, 2'd0);
        cycle(4'b0001, 4'h0, 1'b0, 1'b0, 2'd0);
        check("q0_hold5_a", int'(rd_level), 5);
        repeat (3) cycle(4'h0, 4'h0, 1'b0, 1'b0, 2'd0);
        check("q0_hold5_b", int'(rd_level), 5);
        cycle(4'h0, 4'h0, 1'b1, 1'b0, 2'd0);
        check("q0_read_at_snap", int'(rd_level), 5);
        cycle(4'h0, 4'h0, 1'b0, 1'b0, 2'd0);
        check("q0_after_snap", int'(rd_level), 6);

        // back-to-back frame starts
        cycle(4'h0, 4'h0, 1'b1, 1'b0, 2'd0);
        cycle(4'h0, 4'h0, 1'b1, 1'b0, 2'd0);
        check("b2b_done", int'(snap_done), 1);

        // asynchronous reset mid-traffic
        enq = 4'b0101; deq = 4'b0010; rd_sel = 2'd0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_zero_outputs("async_reset");
        enq = '0; deq = '0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) cycle(4'b0011, 4'h0, 1'b0, 1'b0, 2'd0);
        check("valid_after_reset", int'(snap_valid), 0);
        cycle(4'h0, 4'h0, 1'b1, 1'b0, 2'd0);
        cycle(4'h0, 4'h0, 1'b0, 1'b0, 2'd1);
        check("post_reset_level", int'(rd_level), 3);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cycle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0),
                  2'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
